// File: rtl/imul_seq.sv
// Iterative shift-and-add multiplier: NB iterations of one NB+1-bit add, signed
// operands handled by magnitude multiply plus a final conditional negate.
module imul_seq #(
    parameter int NB = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            iStart,
    input  logic            iSigned,
    input  logic [NB-1:0]   iA,
    input  logic [NB-1:0]   iB,
    output logic [2*NB-1:0] oResult,
    output logic            oBusy,
    output logic            oDone
);

    localparam int CW = $clog2(NB + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [NB-1:0]   r_acc;
    logic [NB-1:0]   r_mplr;
    logic [NB-1:0]   r_mcand;
    logic            r_neg;
    logic [CW-1:0]   r_cnt;
    logic [2*NB-1:0] r_result;

    logic [NB-1:0]   w_mag_a;
    logic [NB-1:0]   w_mag_b;
    logic [NB:0]     w_sum;
    logic [2*NB-1:0] w_prod;
    logic            w_last;

    // -2^(NB-1) negates to itself, which read as unsigned is the correct magnitude.
    assign w_mag_a = (iSigned && iA[NB-1]) ? -iA : iA;
    assign w_mag_b = (iSigned && iB[NB-1]) ? -iB : iB;

    assign w_sum  = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
    // Product as it will stand after this cycle's shift; captured on the final iteration.
    assign w_prod = {w_sum, r_mplr[NB-1:1]};
    assign w_last = (r_cnt == CW'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: w_next gets a default before the case so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (iStart) w_next = S_BUSY;
            S_BUSY:  if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        oBusy   = (r_state == S_BUSY);
        oDone   = (r_state == S_DONE);
        oResult = r_result;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_acc    <= '0;
            r_mplr   <= '0;
            r_mcand  <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_mcand <= w_mag_a;
                        r_mplr  <= w_mag_b;
                        r_neg   <= iSigned & (iA[NB-1] ^ iB[NB-1]);
                        r_acc   <= '0;
                        r_cnt   <= CW'(NB);
                    end
                end
                S_BUSY: begin
                    r_acc  <= w_sum[NB:1];
                    r_mplr <= {w_sum[0], r_mplr[NB-1:1]};
                    r_cnt  <= r_cnt - CW'(1);
                    if (w_last) r_result <= r_neg ? -w_prod : w_prod;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imul_seq.sv
// Directed bench for imul_seq at NB = 16, 8 and 32: handshake timing, signed corners,
// ignored starts, mid-operation reset and result hold across back-to-back operations.
module tb_imul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v [3];
    logic        sgn_v   [3];
    logic [31:0] a_v     [3];
    logic [31:0] b_v     [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [63:0] res_v   [3];
    logic [31:0] res16;
    logic [15:0] res8;
    logic [63:0] res32;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_prev [3];

    always #5 clk = ~clk;

    // Index 0: NB=16, 1: NB=8, 2: NB=32
    imul_seq #(.NB(16)) u_dut16 (
        .Clock(clk), .Reset(rst), .iStart(start_v[0]), .iSigned(sgn_v[0]),
        .iA(a_v[0][15:0]), .iB(b_v[0][15:0]),
        .oResult(res16), .oBusy(busy_v[0]), .oDone(done_v[0])
    );
    imul_seq #(.NB(8)) u_dut8 (
        .Clock(clk), .Reset(rst), .iStart(start_v[1]), .iSigned(sgn_v[1]),
        .iA(a_v[1][7:0]), .iB(b_v[1][7:0]),
        .oResult(res8), .oBusy(busy_v[1]), .oDone(done_v[1])
    );
    imul_seq #(.NB(32)) u_dut32 (
        .Clock(clk), .Reset(rst), .iStart(start_v[2]), .iSigned(sgn_v[2]),
        .iA(a_v[2]), .iB(b_v[2]),
        .oResult(res32), .oBusy(busy_v[2]), .oDone(done_v[2])
    );

    assign res_v[0] = {32'b0, res16};
    assign res_v[1] = {48'b0, res8};
    assign res_v[2] = res32;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nb_of(input int d);
        return (d == 0) ? 16 : (d == 1) ? 8 : 32;
    endfunction

    // Reference: sign/zero-extend to 64 bits, multiply modulo 2^64, keep 2n bits.
    function automatic logic [63:0] model(input int n, input bit s,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ax, bx, mask;
        logic [31:0] am;
        am   = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        mask = (n == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * n)) - 64'd1);
        ax = {32'b0, a & am};
        bx = {32'b0, b & am};
        if (s && ax[n-1]) ax = ax - (64'd1 << n);
        if (s && bx[n-1]) bx = bx - (64'd1 << n);
        return (ax * bx) & mask;
    endfunction

    // Returns in cycle 1 (first BUSY cycle) of the launched operation.
    task automatic launch(input int d, input bit s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_v[d] = 1'b1;
        sgn_v[d]   = s;
        a_v[d]     = a;
        b_v[d]     = b;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    // Launches, checks result hold while busy, latency and product; returns in the DONE cycle.
    task automatic run_op(input int d, input bit s, input logic [31:0] a, input logic [31:0] b,
                          input string tag, output logic [63:0] got);
        int          nb;
        int          lat;
        logic [63:0] exp;
        nb  = nb_of(d);
        exp = model(nb, s, a, b);
        launch(d, s, a, b);
        lat = 1;
        while (!done_v[d] && lat <= nb + 4) begin
            check({tag, "_hold"}, res_v[d], exp_prev[d]);
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(nb + 1));
        check({tag, "_busy_at_done"}, {63'b0, busy_v[d]}, 64'd0);
        check({tag, "_res"}, res_v[d], exp);
        got = res_v[d];
        exp_prev[d] = exp;
    endtask

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs [5];
        logic [63:0] got;
        logic [63:0] seen_res;
        int          n_done;

        vecs[0] = '{1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE_0001};
        vecs[1] = '{1'b1, 32'hFFFF, 32'hFFFF, 64'h0000_0001};
        vecs[2] = '{1'b1, 32'h8000, 32'h8000, 64'h4000_0000};
        vecs[3] = '{1'b1, 32'hFFFD, 32'h0005, 64'hFFFF_FFF1};
        vecs[4] = '{1'b1, 32'h0000, 32'h8000, 64'h0000_0000};

        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0; sgn_v[d] = 1'b0; a_v[d] = '0; b_v[d] = '0; exp_prev[d] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_res", res_v[d], 64'd0);
            check("rst_busy_done", {62'b0, busy_v[d], done_v[d]}, 64'd0);
        end
        rst = 1'b0;

        // Unsigned basic with per-cycle handshake timing
        launch(0, 1'b0, 32'd3, 32'd5);
        for (int c = 1; c <= 16; c++) begin
            check("basic_busy", {62'b0, done_v[0], busy_v[0]}, 64'b01);
            @(negedge clk);
        end
        check("basic_done", {62'b0, done_v[0], busy_v[0]}, 64'b10);
        check("basic_res", res_v[0], 64'h0000_000F);
        @(negedge clk);
        check("basic_idle", {62'b0, done_v[0], busy_v[0]}, 64'b00);
        repeat (3) @(negedge clk);
        check("basic_idle_hold", res_v[0], 64'h0000_000F);
        exp_prev[0] = 64'h0000_000F;

        // Unsigned max and signed corners, hand-computed products
        for (int i = 0; i < 5; i++) begin
            run_op(0, vecs[i].s, vecs[i].a, vecs[i].b, "corner", got);
            check("corner_hand", got, vecs[i].exp);
        end

        // Starts during BUSY (cycle 5) and DONE (cycle 17) are ignored
        launch(0, 1'b0, 32'd7, 32'd9);
        n_done   = 0;
        seen_res = '0;
        for (int c = 1; c <= 40; c++) begin
            start_v[0] = (c == 5 || c == 17);
            a_v[0] = (c == 5 || c == 17) ? 32'd2 : 32'd7;
            b_v[0] = (c == 5 || c == 17) ? 32'd2 : 32'd9;
            if (done_v[0]) begin
                n_done++;
                seen_res = res_v[0];
            end
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        check("ign_done_count", 64'(n_done), 64'd1);
        check("ign_res", seen_res, 64'd63);
        check("ign_res_final", res_v[0], 64'd63);
        exp_prev[0] = 64'd63;

        // Reset at cycle 8 of a 100 x 100
        launch(0, 1'b0, 32'd100, 32'd100);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_res", res_v[0], 64'd0);
        check("midrst_busy_done", {62'b0, busy_v[0], done_v[0]}, 64'd0);
        n_done = 0;
        for (int c = 0; c < 25; c++) begin
            if (done_v[0]) n_done++;
            @(negedge clk);
        end
        check("midrst_no_done", 64'(n_done), 64'd0);
        for (int d = 0; d < 3; d++) exp_prev[d] = '0;
        run_op(0, 1'b0, 32'd4, 32'd4, "after_rst", got);
        check("after_rst_hand", got, 64'd16);

        // Back-to-back: 6 x 7 then 2 x 3 at the first IDLE cycle
        run_op(0, 1'b0, 32'd6, 32'd7, "b2b1", got);
        check("b2b1_hand", got, 64'd42);
        run_op(0, 1'b0, 32'd2, 32'd3, "b2b2", got);
        check("b2b2_hand", got, 64'd6);

        // NB=8 and NB=32: corners then random operands, both modes, back-to-back
        for (int d = 1; d < 3; d++) begin
            int nb;
            nb = nb_of(d);
            run_op(d, 1'b1, 32'h1 << (nb - 1), 32'h1 << (nb - 1), "wide_minmin", got);
            run_op(d, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "wide_umax", got);
            run_op(d, 1'b1, 32'hFFFF_FFFF, 32'd7, "wide_neg1x7", got);
            for (int i = 0; i < 6; i++) begin
                run_op(d, i[0], $urandom, $urandom, "wide_rand", got);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imul_seq.md
# imul_seq

Parametrised iterative shift-and-add integer multiplier with start/done handshake and per-operation signed/unsigned mode. It is the sequential successor of the combinational 16x16 array multiplier used in the datapath. It trades latency (NB+1 cycles) for area: one adder of NB+1 bits instead of an NB x NB full-adder array. It sits behind the ALU/control unit, which launches a multiply with a one-cycle start pulse and collects the 2*NB-bit product when done pulses.

## Interface
- NB, 16, operand width in bits; legal range 2..32; product width is 2*NB.
- Clock  in  1  rising-edge clock; the only clock in the block.
- Reset  in  1  synchronous, active-high reset; sampled on rising Clock.
- iStart  in  1  launch request; sampled only in IDLE.
- iSigned  in  1  1 = two's-complement operands, 0 = unsigned; sampled with iStart.
- iA  in  NB  multiplicand; sampled with iStart.
- iB  in  NB  multiplier; sampled with iStart.
- oResult  out  2*NB  product; valid from the oDone cycle and held until the next accepted start.
- oBusy  out  1  high while an operation is in progress (BUSY state).
- oDone  out  1  one-cycle pulse marking oResult valid.

## Operation
- States: IDLE, BUSY, DONE.
- Reset, whether idle or mid-operation:
  - next state is IDLE;
  - oResult = 0, oBusy = 0, oDone = 0;
  - internal accumulator, operand registers, sign flag and counter are cleared;
  - any operation in flight is discarded with no oDone.
- IDLE with iStart = 1 (accept):
  - Operand registers load |iA| and |iB|, each as NB-bit unsigned. Magnitude is taken only if iSigned = 1 and the MSB is 1; otherwise the raw value is used.
  - The negate flag is set to iSigned & (iA[NB-1] ^ iB[NB-1]).
  - Accumulator is cleared, counter is loaded with NB, state goes to BUSY.
- IDLE with iStart = 0: hold; oResult keeps its last value.
- BUSY, once per cycle:
  - If the multiplier LSB = 1, add the multiplicand to the upper NB bits of the accumulator, with an NB+1-bit carry-out.
  - Shift the {carry, accumulator, multiplier} concatenation right by 1 and decrement the counter.
  - When the counter reaches 1 on this cycle, next state is DONE.
- DONE:
  - oResult is loaded with the 2*NB-bit product, two's-complement negated if the negate flag is set.
  - oDone = 1 for this single cycle; next state is IDLE.
- iStart in BUSY or DONE is ignored; no queueing and no error flag. The caller must wait for oDone.
- Width rules:
  - The most negative signed value, -2^(NB-1), has magnitude 2^(NB-1); this is representable as unsigned NB bits and needs no special case.
  - Unsigned products up to (2^NB-1)^2 fit in 2*NB bits.
  - The signed product range fits in 2*NB bits two's-complement. (-2^(NB-1))^2 = 2^(2NB-2) is positive and fits.
- Zero operand: the full NB iterations still run and the result is 0 with no negative zero. If the negate flag is set, negating 0 gives 0.

## Timing
- Cycle 0: iStart = 1 is sampled in IDLE.
- Cycles 1..NB: state is BUSY, oBusy = 1, oDone = 0.
- Cycle NB+1: state is DONE, oBusy = 0, oDone = 1, new oResult is visible.
- Cycle NB+2: state is IDLE; the earliest new start is sampled here.
- Total latency is NB+1 cycles from the start sample to oDone. Throughput is one operation per NB+2 cycles.
- oResult changes only on the DONE-cycle edge or on Reset. It is stable in all other cycles, including through the next operation's BUSY cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Unsigned basic (NB=16):
  - iA = 3, iB = 5, iSigned = 0, start pulse at cycle 0.
  - oBusy is high for cycles 1..16; oDone pulses at cycle 17 with oResult = 0x0000000F.
- Unsigned max:
  - iA = iB = 0xFFFF, iSigned = 0 -> oResult = 0xFFFE0001.
  - Same operands with iSigned = 1 (-1 x -1) -> oResult = 0x00000001.
- Signed corner and mixed signs:
  - iA = iB = 0x8000, iSigned = 1 -> 0x40000000.
  - iA = 0xFFFD (-3), iB = 5, iSigned = 1 -> 0xFFFFFFF1.
  - iA = 0, iB = 0x8000, iSigned = 1 -> 0x00000000.
- Start during busy: begin 7 x 9, then pulse iStart with iA = 2, iB = 2 at cycles 5 and 17.
  - Both pulses are ignored; oDone appears only once, with oResult = 63.
- Reset mid-operation: begin 100 x 100, assert Reset at cycle 8 for one cycle.
  - All outputs read 0 at cycle 9 and no oDone follows.
  - A fresh 4 x 4 started afterwards returns 16 exactly NB+1 cycles later.
- Back-to-back and hold:
  - Start 6 x 7, then start 2 x 3 at the first IDLE cycle (NB+2).
  - oResult holds 42 through the second operation's BUSY cycles, then becomes 6.
  - Repeat the back-to-back check for NB = 8 and NB = 32, comparing random operands in both modes against a behavioural multiplier.
